// File: rtl/viterbi_depunct_feed_if.sv
// Bus between the deinterleaver side and the depuncture front end.
// Groups the control inputs, the soft-bit input stream, and the decoder pair
// outputs. The master drives enable/start/rate/in_llr/input_strobe and
// observes the pair outputs. The slave is the front end itself.
interface viterbi_depunct_feed_if #(
   parameter int unsigned SOFT_IN_W  = 8,
   parameter int unsigned SOFT_OUT_W = 3,
   parameter int unsigned CNT_W      = 16
);
   logic                  enable;
   logic                  start;
   logic [1:0]            rate;
   logic [SOFT_IN_W-1:0]  in_llr;
   logic                  input_strobe;
   logic [SOFT_OUT_W-1:0] sym0;
   logic [SOFT_OUT_W-1:0] sym1;
   logic [1:0]            erase;
   logic                  output_strobe;
   logic [CNT_W-1:0]      pair_count;
   logic                  rate_err;

   modport master (
      output enable, start, rate, in_llr, input_strobe,
      input  sym0, sym1, erase, output_strobe, pair_count, rate_err
   );

   modport slave (
      input  enable, start, rate, in_llr, input_strobe,
      output sym0, sym1, erase, output_strobe, pair_count, rate_err
   );
endinterface

// File: rtl/viterbi_depunct_feed.sv
// Soft-bit front end for the Viterbi decoder core.
// The block scales and saturates signed LLRs to offset-binary symbols. It
// depunctures rates 1/2, 2/3 and 3/4 by inserting erased symbols, then emits
// the symbol pairs with erase flags and keeps a saturating count of pairs.
// Rate 5/6 is built only when VITERBI_RATE_5_6_EN is defined. Otherwise rate=3
// sets rate_err and the block runs at rate 1/2.
// Ports:
//   clock, reset : system clock and synchronous active-high reset
//   bus (slave)  : enable, start, rate, in_llr, input_strobe in;
//                  sym0, sym1, erase, output_strobe, pair_count, rate_err out
module viterbi_depunct_feed #(
   parameter int unsigned SOFT_IN_W  = 8,
   parameter int unsigned SOFT_OUT_W = 3,
   parameter int unsigned SHIFT      = 5,
   parameter int unsigned CNT_W      = 16
) (
   input logic                   clock,
   input logic                   reset,
   viterbi_depunct_feed_if.slave bus
);

   localparam logic [1:0] RATE_12 = 2'd0;
   localparam logic [1:0] RATE_23 = 2'd1;
   localparam logic [1:0] RATE_34 = 2'd2;
   localparam logic [1:0] RATE_56 = 2'd3;

   localparam logic signed [SOFT_IN_W-1:0] SAT_HI = SOFT_IN_W'(2**(SOFT_OUT_W-1) - 1);
   localparam logic signed [SOFT_IN_W-1:0] SAT_LO = SOFT_IN_W'(-(2**(SOFT_OUT_W-1)));
   localparam logic [SOFT_OUT_W-1:0] ERASE_SYM = {1'b1, {(SOFT_OUT_W-1){1'b0}}};

   // Position inside the puncture period.
   typedef enum logic [2:0] {PH0, PH1, PH2, PH3, PH4, PH5} phase_e;

   phase_e                phase_q, phase_d;
   logic [1:0]            rate_q, rate_d;
   logic                  rate_err_q, rate_err_d;
   logic [SOFT_OUT_W-1:0] held_q, held_d;
   logic [SOFT_OUT_W-1:0] sym0_q, sym0_d;
   logic [SOFT_OUT_W-1:0] sym1_q, sym1_d;
   logic [1:0]            erase_q, erase_d;
   logic                  strobe_q, strobe_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;

   logic signed [SOFT_IN_W-1:0] shifted_c;
   logic [SOFT_OUT_W-1:0]       conv_c;
   logic                        rate_ok_c;
   logic                        emit_c;

   // Scale, saturate, and convert to offset binary. Adding 2^(OW-1) flips the MSB.
   always_comb begin
      shifted_c = $signed(bus.in_llr) >>> SHIFT;
      if (shifted_c > SAT_HI) begin
         conv_c = '1;
      end else if (shifted_c < SAT_LO) begin
         conv_c = '0;
      end else begin
         conv_c = {~shifted_c[SOFT_OUT_W-1], shifted_c[SOFT_OUT_W-2:0]};
      end
   end

`ifdef VITERBI_RATE_5_6_EN
   assign rate_ok_c = 1'b1;
`else
   assign rate_ok_c = (bus.rate != RATE_56);
`endif

   // Next-state and output logic for the depuncture sequence.
   always_comb begin
      phase_d    = phase_q;
      rate_d     = rate_q;
      rate_err_d = rate_err_q;
      held_d     = held_q;
      sym0_d     = sym0_q;
      sym1_d     = sym1_q;
      erase_d    = erase_q;
      strobe_d   = 1'b0;
      cnt_d      = cnt_q;
      emit_c     = 1'b0;

      if (bus.enable) begin
         if (bus.start) begin
            // Start applies first. A same-cycle input becomes A0 of the new rate.
            rate_d     = rate_ok_c ? bus.rate : RATE_12;
            rate_err_d = !rate_ok_c;
            cnt_d      = '0;
            held_d     = '0;
            phase_d    = PH0;
            if (bus.input_strobe) begin
               held_d  = conv_c;
               phase_d = PH1;
            end
         end else if (bus.input_strobe) begin
            unique case (phase_q)
               PH0: begin
                  held_d  = conv_c;
                  phase_d = PH1;
               end
               PH1: begin
                  emit_c  = 1'b1;
                  sym0_d  = held_q;
                  sym1_d  = conv_c;
                  erase_d = 2'b00;
                  phase_d = (rate_q == RATE_12) ? PH0 : PH2;
               end
               PH2: begin
                  emit_c  = 1'b1;
                  sym0_d  = conv_c;
                  sym1_d  = ERASE_SYM;
                  erase_d = 2'b10;
                  phase_d = (rate_q == RATE_23) ? PH0 : PH3;
               end
               PH3: begin
                  emit_c  = 1'b1;
                  sym0_d  = ERASE_SYM;
                  sym1_d  = conv_c;
                  erase_d = 2'b01;
`ifdef VITERBI_RATE_5_6_EN
                  phase_d = (rate_q == RATE_56) ? PH4 : PH0;
`else
                  phase_d = PH0;
`endif
               end
`ifdef VITERBI_RATE_5_6_EN
               PH4: begin
                  emit_c  = 1'b1;
                  sym0_d  = conv_c;
                  sym1_d  = ERASE_SYM;
                  erase_d = 2'b10;
                  phase_d = PH5;
               end
               PH5: begin
                  emit_c  = 1'b1;
                  sym0_d  = ERASE_SYM;
                  sym1_d  = conv_c;
                  erase_d = 2'b01;
                  phase_d = PH0;
               end
`endif
               default: phase_d = PH0;
            endcase
         end
      end

      if (emit_c) begin
         strobe_d = 1'b1;
         cnt_d    = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
      end
   end

   // State and output registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         phase_q    <= PH0;
         rate_q     <= RATE_12;
         rate_err_q <= 1'b0;
         held_q     <= '0;
         sym0_q     <= '0;
         sym1_q     <= '0;
         erase_q    <= 2'b00;
         strobe_q   <= 1'b0;
         cnt_q      <= '0;
      end else begin
         phase_q    <= phase_d;
         rate_q     <= rate_d;
         rate_err_q <= rate_err_d;
         held_q     <= held_d;
         sym0_q     <= sym0_d;
         sym1_q     <= sym1_d;
         erase_q    <= erase_d;
         strobe_q   <= strobe_d;
         cnt_q      <= cnt_d;
      end
   end

   assign bus.sym0          = sym0_q;
   assign bus.sym1          = sym1_q;
   assign bus.erase         = erase_q;
   assign bus.output_strobe = strobe_q;
   assign bus.pair_count    = cnt_q;
   assign bus.rate_err      = rate_err_q;

endmodule
